// File: rtl/id_ex_hazard_reg.sv
// D->E pipeline register with hazard/stall generation for a 5-stage MIPS core.
// Compares the D-stage Tuse against the E/M-stage Tnew, and tracks the multi-cycle
// mult/div unit so that HI/LO users wait while it is busy. Stalls and flushes
// insert bubbles (all-zero E state, i.e. sll $0,$0,0) into E.
module id_ex_hazard_reg #(
  parameter int unsigned MultCycles = 5,
  parameter int unsigned DivCycles  = 10
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_e_i,
  // D-stage instruction and operands
  input  logic [31:0] instr_d_i,
  input  logic [31:0] pc8_d_i,
  input  logic [31:0] rs_data_d_i,
  input  logic [31:0] rt_data_d_i,
  input  logic [4:0]  a1_d_i,
  input  logic [4:0]  a2_d_i,
  input  logic [4:0]  a3_d_i,
  input  logic        regwrite_d_i,
  input  logic [1:0]  tnew_d_i,
  input  logic [1:0]  tuse_rs_d_i,
  input  logic [1:0]  tuse_rt_d_i,
  input  logic        md_start_d_i,
  input  logic        md_div_d_i,
  input  logic        md_use_d_i,
  // M-stage producer information
  input  logic [4:0]  a3_m_i,
  input  logic        regwrite_m_i,
  input  logic [1:0]  tnew_m_i,
  // Hazard outputs
  output logic        stall_o,
  output logic        md_busy_o,
  // E-stage copies
  output logic [31:0] instr_e_o,
  output logic [31:0] pc8_e_o,
  output logic [31:0] rs_data_e_o,
  output logic [31:0] rt_data_e_o,
  output logic [4:0]  a1_e_o,
  output logic [4:0]  a2_e_o,
  output logic [4:0]  a3_e_o,
  output logic        regwrite_e_o,
  output logic [1:0]  tnew_e_o
);

  localparam int unsigned MaxCycles = (MultCycles > DivCycles) ? MultCycles : DivCycles;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  // The start cycle in E is the first busy cycle, so the counter covers the rest.
  localparam logic [CntW-1:0] MultLoad = CntW'(MultCycles - 1);
  localparam logic [CntW-1:0] DivLoad  = CntW'(DivCycles - 1);

  // E-stage state
  logic [31:0]     instr_q, instr_d;
  logic [31:0]     pc8_q, pc8_d;
  logic [31:0]     rs_data_q, rs_data_d;
  logic [31:0]     rt_data_q, rt_data_d;
  logic [4:0]      a1_q, a1_d;
  logic [4:0]      a2_q, a2_d;
  logic [4:0]      a3_q, a3_d;
  logic            regwrite_q, regwrite_d;
  logic [1:0]      tnew_q, tnew_d;
  logic            md_start_q, md_start_d;
  logic            md_div_q, md_div_d;
  logic [CntW-1:0] md_cnt_q, md_cnt_d;

  logic md_busy;
  logic stall_rs_e, stall_rs_m, stall_rt_e, stall_rt_m, stall_md;
  logic stall;
  logic bubble;

  // A read-after-write hazard exists when the source matches a live, non-$0 producer
  // whose result arrives later than the consumer needs it. Tuse=3 can never be less
  // than a 2-bit Tnew, and Tnew=0 is never greater than any Tuse.
  function automatic logic raw_hazard(input logic [4:0] src,
                                      input logic [1:0] tuse,
                                      input logic [4:0] dst,
                                      input logic       we,
                                      input logic [1:0] tnew);
    return (src == dst) && (dst != 5'd0) && we && (tuse < tnew);
  endfunction

  // Stall decision from GPR dependencies and the mult/div unit.
  always_comb begin
    md_busy    = md_start_q | (md_cnt_q != '0);
    stall_rs_e = raw_hazard(a1_d_i, tuse_rs_d_i, a3_q,   regwrite_q,   tnew_q);
    stall_rs_m = raw_hazard(a1_d_i, tuse_rs_d_i, a3_m_i, regwrite_m_i, tnew_m_i);
    stall_rt_e = raw_hazard(a2_d_i, tuse_rt_d_i, a3_q,   regwrite_q,   tnew_q);
    stall_rt_m = raw_hazard(a2_d_i, tuse_rt_d_i, a3_m_i, regwrite_m_i, tnew_m_i);
    stall_md   = md_use_d_i & md_busy;
    stall      = stall_rs_e | stall_rs_m | stall_rt_e | stall_rt_m | stall_md;
    bubble     = flush_e_i | stall;
  end

  // Next E state: bubble on flush or stall, otherwise capture the D stage.
  always_comb begin
    instr_d    = instr_d_i;
    pc8_d      = pc8_d_i;
    rs_data_d  = rs_data_d_i;
    rt_data_d  = rt_data_d_i;
    a1_d       = a1_d_i;
    a2_d       = a2_d_i;
    a3_d       = a3_d_i;
    regwrite_d = regwrite_d_i;
    tnew_d     = tnew_d_i;
    md_start_d = md_start_d_i;
    md_div_d   = md_div_d_i;
    if (bubble) begin
      instr_d    = '0;
      pc8_d      = '0;
      rs_data_d  = '0;
      rt_data_d  = '0;
      a1_d       = '0;
      a2_d       = '0;
      a3_d       = '0;
      regwrite_d = 1'b0;
      tnew_d     = '0;
      md_start_d = 1'b0;
      md_div_d   = 1'b0;
    end
  end

  // Mult/div busy counter: load on a start in E, otherwise count down to zero.
  // A flush does not touch it, so a running operation always completes.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_start_q) begin
      md_cnt_d = md_div_q ? DivLoad : MultLoad;
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - 1'b1;
    end
  end

  // E-stage register and mult/div counter state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instr_q    <= '0;
      pc8_q      <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      a1_q       <= '0;
      a2_q       <= '0;
      a3_q       <= '0;
      regwrite_q <= 1'b0;
      tnew_q     <= '0;
      md_start_q <= 1'b0;
      md_div_q   <= 1'b0;
      md_cnt_q   <= '0;
    end else begin
      instr_q    <= instr_d;
      pc8_q      <= pc8_d;
      rs_data_q  <= rs_data_d;
      rt_data_q  <= rt_data_d;
      a1_q       <= a1_d;
      a2_q       <= a2_d;
      a3_q       <= a3_d;
      regwrite_q <= regwrite_d;
      tnew_q     <= tnew_d;
      md_start_q <= md_start_d;
      md_div_q   <= md_div_d;
      md_cnt_q   <= md_cnt_d;
    end
  end

  // Output mapping.
  always_comb begin
    stall_o      = stall;
    md_busy_o    = md_busy;
    instr_e_o    = instr_q;
    pc8_e_o      = pc8_q;
    rs_data_e_o  = rs_data_q;
    rt_data_e_o  = rt_data_q;
    a1_e_o       = a1_q;
    a2_e_o       = a2_q;
    a3_e_o       = a3_q;
    regwrite_e_o = regwrite_q;
    tnew_e_o     = tnew_q;
  end

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Scoreboard bench for id_ex_hazard_reg: the driver pushes hand-computed expectations
// per cycle, and a monitor pops and compares them on the falling clock edge.
module tb_id_ex_hazard_reg;

  typedef struct packed {
    logic [31:0] instr, pc8, rs, rt;
    logic [4:0]  a1, a2, a3;
    logic        rw;
    logic [1:0]  tnew, trs, trt;
    logic        mds, mdd, mdu;
  } dvec_t;

  typedef struct packed {
    logic [31:0] instr, pc8, rs, rt;
    logic [4:0]  a1, a2, a3;
    logic        rw;
    logic [1:0]  tnew;
  } evec_t;

  typedef struct packed {
    logic  stall;
    logic  busy;
    evec_t e;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_e = 1'b0;
  logic [31:0] instr_d = '0, pc8_d = '0, rs_d = '0, rt_d = '0;
  logic [4:0]  a1_d = '0, a2_d = '0, a3_d = '0;
  logic        rw_d = 1'b0;
  logic [1:0]  tnew_d = '0, trs_d = '0, trt_d = '0;
  logic        mds_d = 1'b0, mdd_d = 1'b0, mdu_d = 1'b0;
  logic [4:0]  a3_m = '0;
  logic        rw_m = 1'b0;
  logic [1:0]  tnew_m = '0;

  logic        stall, md_busy;
  logic [31:0] instr_e, pc8_e, rs_e, rt_e;
  logic [4:0]  a1_e, a2_e, a3_e;
  logic        rw_e;
  logic [1:0]  tnew_e;
  evec_t       act_e;

  int n_chk = 0;
  int n_fail = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  id_ex_hazard_reg #(.MultCycles(5), .DivCycles(10)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_e_i(flush_e),
    .instr_d_i(instr_d), .pc8_d_i(pc8_d), .rs_data_d_i(rs_d), .rt_data_d_i(rt_d),
    .a1_d_i(a1_d), .a2_d_i(a2_d), .a3_d_i(a3_d), .regwrite_d_i(rw_d),
    .tnew_d_i(tnew_d), .tuse_rs_d_i(trs_d), .tuse_rt_d_i(trt_d),
    .md_start_d_i(mds_d), .md_div_d_i(mdd_d), .md_use_d_i(mdu_d),
    .a3_m_i(a3_m), .regwrite_m_i(rw_m), .tnew_m_i(tnew_m),
    .stall_o(stall), .md_busy_o(md_busy),
    .instr_e_o(instr_e), .pc8_e_o(pc8_e), .rs_data_e_o(rs_e), .rt_data_e_o(rt_e),
    .a1_e_o(a1_e), .a2_e_o(a2_e), .a3_e_o(a3_e), .regwrite_e_o(rw_e), .tnew_e_o(tnew_e)
  );

  assign act_e = {instr_e, pc8_e, rs_e, rt_e, a1_e, a2_e, a3_e, rw_e, tnew_e};

  function automatic dvec_t mk(input logic [31:0] instr, input logic [4:0] a1,
                               input logic [4:0] a2, input logic [4:0] a3, input logic rw,
                               input logic [1:0] tnew, input logic [1:0] trs,
                               input logic [1:0] trt, input logic mds, input logic mdd,
                               input logic mdu);
    dvec_t v;
    v.instr = instr;
    v.pc8   = ~instr;
    v.rs    = instr ^ 32'h5a5a_0000;
    v.rt    = instr ^ 32'h0000_a5a5;
    v.a1 = a1; v.a2 = a2; v.a3 = a3; v.rw = rw; v.tnew = tnew;
    v.trs = trs; v.trt = trt; v.mds = mds; v.mdd = mdd; v.mdu = mdu;
    return v;
  endfunction

  function automatic evec_t to_e(input dvec_t d);
    return {d.instr, d.pc8, d.rs, d.rt, d.a1, d.a2, d.a3, d.rw, d.tnew};
  endfunction

  // One cycle: apply D/M inputs just after the rising edge and queue the expectation.
  task automatic cyc(input dvec_t d, input logic [4:0] am, input logic rm,
                     input logic [1:0] tm, input logic fl, input logic rst_val,
                     input logic exp_stall, input logic exp_busy, input evec_t exp_e,
                     input logic assert_rst_mid);
    exp_t x;
    @(posedge clk);
    #1;
    rst_n   = rst_val;
    instr_d = d.instr; pc8_d = d.pc8; rs_d = d.rs; rt_d = d.rt;
    a1_d = d.a1; a2_d = d.a2; a3_d = d.a3; rw_d = d.rw; tnew_d = d.tnew;
    trs_d = d.trs; trt_d = d.trt; mds_d = d.mds; mdd_d = d.mdd; mdu_d = d.mdu;
    a3_m = am; rw_m = rm; tnew_m = tm; flush_e = fl;
    x.stall = exp_stall;
    x.busy  = exp_busy;
    x.e     = exp_e;
    sb_q.push_back(x);
    if (assert_rst_mid) begin
      #1;
      rst_n = 1'b0;
    end
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        n_chk += 3;
        if (stall !== x.stall) begin
          n_fail++;
          $display("FAIL stall @%0t: got %b expected %b", $time, stall, x.stall);
        end
        if (md_busy !== x.busy) begin
          n_fail++;
          $display("FAIL md_busy @%0t: got %b expected %b", $time, md_busy, x.busy);
        end
        if (act_e !== x.e) begin
          n_fail++;
          $display("FAIL e_regs @%0t: got %h expected %h", $time, act_e, x.e);
        end
      end
    end
  end

  initial begin
    dvec_t lw1, addu2, beq2, addu0, beq0, sw1, lw7, addu8;
    dvec_t div1, mfhi, mult, mflo, v1, v2, v3, div2, idle;
    evec_t e0;
    e0    = '0;
    idle  = '0;
    //          instr          a1  a2  a3 rw tn trs trt mds mdd mdu
    lw1   = mk(32'h8fa1_0000, 29,  0,  1, 1, 2, 1,  3,  0,  0,  0);
    addu2 = mk(32'h0023_1021,  1,  3,  2, 1, 1, 1,  1,  0,  0,  0);
    beq2  = mk(32'h1040_0004,  2,  0,  0, 0, 0, 0,  0,  0,  0,  0);
    addu0 = mk(32'h0085_0021,  4,  5,  0, 1, 1, 1,  1,  0,  0,  0);
    beq0  = mk(32'h1000_0002,  0,  0,  0, 0, 0, 0,  0,  0,  0,  0);
    sw1   = mk(32'hafa1_0004, 29,  1,  0, 0, 0, 1,  2,  0,  0,  0);
    lw7   = mk(32'h8fa7_0008, 29,  0,  7, 1, 2, 1,  3,  0,  0,  0);
    addu8 = mk(32'h00c7_4021,  6,  7,  8, 1, 1, 1,  1,  0,  0,  0);
    div1  = mk(32'h012a_001a,  9, 10,  0, 0, 0, 1,  1,  1,  1,  1);
    mfhi  = mk(32'h0000_5810,  0,  0, 11, 1, 1, 3,  3,  0,  0,  1);
    mult  = mk(32'h018d_0018, 12, 13,  0, 0, 0, 1,  1,  1,  0,  1);
    mflo  = mk(32'h0000_7012,  0,  0, 14, 1, 1, 3,  3,  0,  0,  1);
    v1    = mk(32'h01f0_8821, 15, 16, 17, 1, 1, 1,  1,  0,  0,  0);
    v2    = mk(32'h0240_9821, 18,  0, 19, 1, 1, 1,  3,  0,  0,  0);
    v3    = mk(32'h0274_a821, 19, 20, 21, 1, 2, 1,  1,  0,  0,  0);
    div2  = mk(32'h02d7_001a, 22, 23,  0, 0, 0, 1,  1,  1,  1,  1);

    // Reset held low: E outputs zero even with a live D instruction.
    cyc(v1,    0, 0, 0, 0, 0, 0, 0, e0, 0);
    // Load-use on rs through E, then through M with Tuse == Tnew (no stall).
    cyc(lw1,   0, 0, 0, 0, 1, 0, 0, e0, 0);
    cyc(addu2, 0, 0, 0, 0, 1, 1, 0, to_e(lw1), 0);
    cyc(addu2, 1, 1, 1, 0, 1, 0, 0, e0, 0);
    // Branch with Tuse 0 against ALU result in E, then in M, then resolved.
    cyc(beq2,  0, 0, 0, 0, 1, 1, 0, to_e(addu2), 0);
    cyc(beq2,  2, 1, 1, 0, 1, 1, 0, e0, 0);
    cyc(beq2,  2, 1, 0, 0, 1, 0, 0, e0, 0);
    // Writer of $0 in E never stalls a $0 reader.
    cyc(addu0, 0, 0, 0, 0, 1, 0, 0, to_e(beq2), 0);
    cyc(beq0,  0, 0, 0, 0, 1, 0, 0, to_e(addu0), 0);
    // Store data Tuse 2 against load Tnew 2: no stall.
    cyc(lw1,   0, 0, 0, 0, 1, 0, 0, to_e(beq0), 0);
    cyc(sw1,   0, 0, 0, 0, 1, 0, 0, to_e(lw1), 0);
    // rt dependency through E (stall), then through M (no stall).
    cyc(lw7,   0, 0, 0, 0, 1, 0, 0, to_e(sw1), 0);
    cyc(addu8, 0, 0, 0, 0, 1, 1, 0, to_e(lw7), 0);
    cyc(addu8, 7, 1, 1, 0, 1, 0, 0, e0, 0);
    // div: mfhi stalls for exactly 10 cycles, captured on the 11th.
    cyc(div1,  0, 0, 0, 0, 1, 0, 0, to_e(addu8), 0);
    cyc(mfhi,  0, 0, 0, 0, 1, 1, 1, to_e(div1), 0);
    for (int i = 0; i < 9; i++) cyc(mfhi, 0, 0, 0, 0, 1, 1, 1, e0, 0);
    cyc(mfhi,  0, 0, 0, 0, 1, 0, 0, e0, 0);
    // mult: mflo stalls for exactly 5 cycles.
    cyc(mult,  0, 0, 0, 0, 1, 0, 0, to_e(mfhi), 0);
    cyc(mflo,  0, 0, 0, 0, 1, 1, 1, to_e(mult), 0);
    for (int i = 0; i < 4; i++) cyc(mflo, 0, 0, 0, 0, 1, 1, 1, e0, 0);
    cyc(mflo,  0, 0, 0, 0, 1, 0, 0, e0, 0);
    // Flush alone, then flush together with a stall.
    cyc(v1,    0, 0, 0, 1, 1, 0, 0, to_e(mflo), 0);
    cyc(v2,   18, 1, 2, 1, 1, 1, 0, e0, 0);
    cyc(v3,    0, 0, 0, 0, 1, 0, 0, e0, 0);
    // div then asynchronous reset when the counter holds 4.
    cyc(div2,  0, 0, 0, 0, 1, 0, 0, to_e(v3), 0);
    cyc(mfhi,  0, 0, 0, 0, 1, 1, 1, to_e(div2), 0);
    for (int i = 0; i < 5; i++) cyc(mfhi, 0, 0, 0, 0, 1, 1, 1, e0, 0);
    cyc(mfhi,  0, 0, 0, 0, 1, 0, 0, e0, 1);
    cyc(mfhi,  0, 0, 0, 0, 0, 0, 0, e0, 0);
    // Release reset and confirm normal capture resumes.
    cyc(idle,  0, 0, 0, 0, 1, 0, 0, e0, 0);
    cyc(v1,    0, 0, 0, 0, 1, 0, 0, e0, 0);
    cyc(idle,  0, 0, 0, 0, 1, 0, 0, to_e(v1), 0);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
